// File: rtl/seg_pkg.sv
// Shared segment patterns and helpers for the scanned seven-segment display.
package seg_pkg;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  localparam logic [7:0] SEG_MINUS = 8'h40;
  localparam logic [7:0] SEG_ERR   = 8'h79;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Width of the digit index covering all magnitude digits plus the sign digit.
  function automatic int idx_width(input int num_digits);
    int w;
    w = $clog2(num_digits + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic logic bcd_invalid(input logic [3:0] d);
    return d > 4'd9;
  endfunction

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] p;
    p = SEG_ERR[6:0];
    for (int i = 0; i < 10; i++) begin
      if (d == 4'(i)) p = SEG_DIGIT[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational BCD digit to segment pattern, flagging codes above 9.
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] pattern,
  output logic       invalid
);

  always_comb begin
    pattern = bcd_to_seg(digit);
    invalid = bcd_invalid(digit);
  end

endmodule

// File: rtl/seven_segment_scan.sv
// Time-multiplexed signed BCD display driver with leading-zero blanking.
// Optional blinking of the whole display is enabled by defining SEG_BLINK_EN.
module seven_segment_scan
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 5,
  parameter int SCAN_DIV       = 1000,
  parameter int SEG_ACTIVE_LOW = 0
`ifdef SEG_BLINK_EN
  ,
  parameter int BLINK_FRAMES   = 50
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*NUM_DIGITS:0] bcd_in,
  input  logic [NUM_DIGITS-1:0] dp_in,
`ifdef SEG_BLINK_EN
  input  logic                  blink,
`endif
  output logic [7:0]            seg,
  output logic [NUM_DIGITS:0]   an,
  output logic                  frame_start,
  output logic                  err
);

  localparam int BW    = 4 * NUM_DIGITS + 1;
  localparam int IDX_W = idx_width(NUM_DIGITS);
  localparam int CNT_W = $clog2(SCAN_DIV);

  localparam logic [CNT_W-1:0]    DIV_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(NUM_DIGITS);
  localparam logic [7:0]          SEG_MASK = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS:0] AN_MASK  =
    (SEG_ACTIVE_LOW != 0) ? {(NUM_DIGITS + 1){1'b1}} : {(NUM_DIGITS + 1){1'b0}};

  logic [BW-1:0]         shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0] dp_q, dp_d;
  logic [CNT_W-1:0]      div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  wrap_q, wrap_d;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS:0]   an_q, an_d;
  logic                  frame_start_q, frame_start_d;
  logic                  err_q, err_d;

  logic                  div_wrap;
  logic                  visible_d;

  always_comb begin
    shadow_d = shadow_q;
    dp_d     = dp_q;
    if (load) begin
      shadow_d = bcd_in;
      dp_d     = dp_in;
    end
  end

  // Scan timing runs independently of loads; wrap_q marks the first cycle of a new frame.
  always_comb begin
    div_wrap  = (div_cnt_q == DIV_LAST);
    div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;
    idx_d     = idx_q;
    if (div_wrap) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    wrap_d    = div_wrap && (idx_q == IDX_LAST);
  end

  logic [NUM_DIGITS-1:0] keep;
  logic                  mag_nz;
  logic                  err_any;

  // keep[k]: some digit at position k or above is nonzero, so digit k is not a leading zero.
  always_comb begin
    keep    = '0;
    mag_nz  = 1'b0;
    err_any = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      mag_nz  = mag_nz | (shadow_q[4*k +: 4] != 4'd0);
      keep[k] = mag_nz || (k == 0);
      err_any = err_any | bcd_invalid(shadow_q[4*k +: 4]);
    end
  end

  logic [3:0] cur_digit;
  logic       cur_dp;
  logic       cur_keep;
  logic       is_sign;

  always_comb begin
    cur_digit = '0;
    cur_dp    = 1'b0;
    cur_keep  = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_digit = shadow_q[4*k +: 4];
        cur_dp    = dp_q[k];
        cur_keep  = keep[k];
      end
    end
    is_sign = (idx_q == IDX_LAST);
  end

  logic [6:0] dec_pattern;
  logic       dec_invalid;

  seg_decoder u_dec (
    .digit   (cur_digit),
    .pattern (dec_pattern),
    .invalid (dec_invalid)
  );

`ifdef SEG_BLINK_EN
  localparam int BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BF_W-1:0] BF_LAST = BF_W'(BLINK_FRAMES - 1);

  logic [BF_W-1:0] blink_cnt_q, blink_cnt_d;
  logic            visible_q;

  // Phase is resolved for the frame about to start so gating lines up with frame boundaries.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    visible_d   = visible_q;
    if (!blink) begin
      blink_cnt_d = '0;
      visible_d   = 1'b1;
    end else if (wrap_q) begin
      if (blink_cnt_q == BF_LAST) begin
        blink_cnt_d = '0;
        visible_d   = !visible_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_q <= '0;
      visible_q   <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      visible_q   <= visible_d;
    end
  end
`else
  assign visible_d = 1'b1;
`endif

  logic [7:0]          seg_raw;
  logic [NUM_DIGITS:0] an_raw;

  always_comb begin
    if (is_sign) begin
      seg_raw = {1'b0, (shadow_q[BW-1] && mag_nz) ? SEG_MINUS[6:0] : SEG_BLANK[6:0]};
    end else begin
      seg_raw = {cur_dp, cur_keep ? dec_pattern : SEG_BLANK[6:0]};
    end
    an_raw = '0;
    for (int k = 0; k <= NUM_DIGITS; k++) begin
      an_raw[k] = (idx_q == IDX_W'(k)) && visible_d;
    end
    seg_d         = seg_raw ^ SEG_MASK;
    an_d          = an_raw ^ AN_MASK;
    frame_start_d = wrap_q;
    err_d         = err_any | dec_invalid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q      <= '0;
      dp_q          <= '0;
      div_cnt_q     <= '0;
      idx_q         <= '0;
      wrap_q        <= 1'b0;
      seg_q         <= SEG_MASK;
      an_q          <= AN_MASK;
      frame_start_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      shadow_q      <= shadow_d;
      dp_q          <= dp_d;
      div_cnt_q     <= div_cnt_d;
      idx_q         <= idx_d;
      wrap_q        <= wrap_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
      frame_start_q <= frame_start_d;
      err_q         <= err_d;
    end
  end

  assign seg         = seg_q;
  assign an          = an_q;
  assign frame_start = frame_start_q;
  assign err         = err_q;

endmodule

// File: tb/tb_seven_segment_scan.sv
// Directed scoreboard bench for seven_segment_scan with NUM_DIGITS=5, SCAN_DIV=4.
module tb_seven_segment_scan;

  localparam int ND = 5;
  localparam int SD = 4;
  localparam int FRAME = (ND + 1) * SD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [20:0] bcd_in = '0;
  logic [4:0]  dp_in = '0;
  logic [7:0]  seg;
  logic [5:0]  an;
  logic        frame_start;
  logic        err;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  typedef struct packed {
    logic            err;
    logic [5:0][7:0] segs;
  } exp_t;

  exp_t sb[$];

  seven_segment_scan #(
    .NUM_DIGITS     (ND),
    .SCAN_DIV       (SD),
    .SEG_ACTIVE_LOW (0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .bcd_in      (bcd_in),
    .dp_in       (dp_in),
    .seg         (seg),
    .an          (an),
    .frame_start (frame_start),
    .err         (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [6:0] dseg(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h79;
    endcase
  endfunction

  function automatic exp_t model(input logic [20:0] b, input logic [4:0] dp);
    exp_t       e;
    int         hi;
    logic       nz;
    logic [3:0] d;
    e  = '0;
    hi = 0;
    nz = 1'b0;
    for (int k = 0; k < ND; k++) begin
      if (b[4*k +: 4] != 4'd0) begin
        hi = k;
        nz = 1'b1;
      end
    end
    for (int k = 0; k < ND; k++) begin
      d = b[4*k +: 4];
      if (d > 4'd9) e.err = 1'b1;
      e.segs[k] = {dp[k], (k > hi) ? 7'h00 : dseg(d)};
    end
    e.segs[ND] = {1'b0, (b[20] && nz) ? 7'h40 : 7'h00};
    return e;
  endfunction

  task automatic load_word(input logic [20:0] b, input logic [4:0] dp);
    @(negedge clk);
    load   = 1'b1;
    bcd_in = b;
    dp_in  = dp;
    @(negedge clk);
    load = 1'b0;
    sb.push_back(model(b, dp));
  endtask

  // Frame right after reset release: no frame_start until the scan wraps.
  task automatic check_first_frame(input string tag);
    exp_t e;
    e = sb.pop_front();
    for (int j = 0; j < FRAME; j++) begin
      @(negedge clk);
      chk($sformatf("%s.fs[%0d]", tag, j), 32'(frame_start), 32'd0);
      chk($sformatf("%s.an[%0d]", tag, j), 32'(an), 32'(6'b1 << (j / SD)));
      chk($sformatf("%s.seg[%0d]", tag, j), 32'(seg), 32'(e.segs[j / SD]));
    end
    @(negedge clk);
    chk({tag, ".fs_wrap"}, 32'(frame_start), 32'd1);
    chk({tag, ".an_wrap"}, 32'(an), 32'd1);
  endtask

  task automatic check_frame(input string tag);
    exp_t e;
    int   n;
    e = sb.pop_front();
    n = 0;
    @(negedge clk);
    while (frame_start !== 1'b1 && n < 4 * FRAME) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".fs_wait"}, 32'(frame_start), 32'd1);
    for (int j = 0; j < FRAME; j++) begin
      if (j > 0) begin
        @(negedge clk);
        chk($sformatf("%s.fs[%0d]", tag, j), 32'(frame_start), 32'd0);
      end
      chk($sformatf("%s.an[%0d]", tag, j), 32'(an), 32'(6'b1 << (j / SD)));
      chk($sformatf("%s.seg[%0d]", tag, j), 32'(seg), 32'(e.segs[j / SD]));
    end
    chk({tag, ".err"}, 32'(err), 32'(e.err));
  endtask

  task automatic wait_an(input logic [5:0] target);
    int n;
    n = 0;
    @(negedge clk);
    while (an !== target && n < 4 * FRAME) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("wait_an_%0h", target), 32'(an), 32'(target));
  endtask

  initial begin
    int fs_cnt;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst.seg", 32'(seg), 32'h00);
    chk("rst.an", 32'(an), 32'h00);
    chk("rst.fs", 32'(frame_start), 32'd0);
    chk("rst.err", 32'(err), 32'd0);

    // scan from reset with an all-zero shadow
    rst = 1'b0;
    sb.push_back(model(21'h0, 5'h0));
    check_first_frame("scan0");
    fs_cnt = 0;
    for (int j = 0; j < 2 * FRAME; j++) begin
      @(negedge clk);
      if (frame_start === 1'b1) fs_cnt++;
    end
    chk("scan.fs_count", 32'(fs_cnt), 32'd2);

    // leading-zero blanking, dp shown on a blanked digit
    load_word(21'h000123, 5'b10000);
    check_frame("blank");

    // negative number, then back-to-back loads ending in negative zero
    load_word({1'b1, 20'h12345}, 5'b00010);
    check_frame("neg");
    @(negedge clk);
    load   = 1'b1;
    bcd_in = {1'b1, 20'h98765};
    dp_in  = 5'b11111;
    @(negedge clk);
    bcd_in = {1'b1, 20'h00000};
    dp_in  = 5'b00000;
    @(negedge clk);
    load = 1'b0;
    sb.push_back(model({1'b1, 20'h00000}, 5'b00000));
    check_frame("negzero");

    // invalid digit: err rises exactly one cycle after the load edge
    @(negedge clk);
    load   = 1'b1;
    bcd_in = {1'b1, 20'h0F001};
    dp_in  = 5'b00000;
    @(negedge clk);
    load = 1'b0;
    chk("err.lat0", 32'(err), 32'd0);
    @(negedge clk);
    chk("err.lat1", 32'(err), 32'd1);
    sb.push_back(model({1'b1, 20'h0F001}, 5'b00000));
    check_frame("invalid");

    // mid-scan load while digit 2 is enabled
    load_word(21'h054321, 5'b00000);
    check_frame("pre_mid");
    wait_an(6'b000010);
    wait_an(6'b000100);
    load   = 1'b1;
    bcd_in = 21'h054921;
    @(negedge clk);
    load = 1'b0;
    chk("mid.an1", 32'(an), 32'h04);
    chk("mid.seg_old", 32'(seg), 32'h4F);
    @(negedge clk);
    chk("mid.an2", 32'(an), 32'h04);
    chk("mid.seg_new", 32'(seg), 32'h6F);
    @(negedge clk);
    chk("mid.an3", 32'(an), 32'h04);
    @(negedge clk);
    chk("mid.an_next", 32'(an), 32'h08);
    sb.push_back(model(21'h054921, 5'b00000));
    check_frame("post_mid");

    // asynchronous reset in the middle of a frame
    load_word(21'h0000A0, 5'b00001);
    repeat (6) @(negedge clk);
    chk("pre_rst.err", 32'(err), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst.seg", 32'(seg), 32'h00);
    chk("arst.an", 32'(an), 32'h00);
    chk("arst.fs", 32'(frame_start), 32'd0);
    chk("arst.err", 32'(err), 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    sb.push_back(model(21'h0, 5'h0));
    check_first_frame("scan1");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
